instr_prefetch_buf: RTL and testbench
=====================================

# instr_prefetch_buf

Instruction prefetch buffer between the instruction-memory bus and the core's fetch stage. It issues sequential word fetches over a req/gnt/rvalid bus, holds returned instructions with their PCs in a small FIFO, and presents them to the fetch stage through a valid/ready handshake. A redirect (branch/jump) flushes the buffer and restarts fetching from the new target. Responses still in flight at the time of a redirect are dropped.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- BOOT_ADDR, 32'h0000_0000, first fetch address after reset
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- req_i  in  1  core wants instructions; 0 stops new bus requests (in-flight ones still complete)
- branch_i  in  1  redirect strobe, one cycle
- branch_addr_i  in  32  redirect target; bits [1:0] ignored
- fetch_valid_o  out  1  head entry valid
- fetch_rdata_o  out  32  head instruction
- fetch_addr_o  out  32  PC of head instruction
- fetch_ready_i  in  1  fetch stage consumes head when fetch_valid_o && fetch_ready_i
- instr_req_o  out  1  bus request
- instr_addr_o  out  32  word-aligned bus address
- instr_gnt_i  in  1  request accepted
- instr_rvalid_i  in  1  response valid; in order, earliest 1 cycle after gnt
- instr_rdata_i  in  32  response data
- busy_o  out  1  outstanding bus transactions ≠ 0

## Operation
- State: fetch address register (faddr), FIFO of {addr, data}, outstanding counter (0..2), discard counter (0..2).
- Issue rule: instr_req_o = req_i && outstanding < 2 && (fifo_count + outstanding) < DEPTH, evaluated from registered state. Exception: once instr_req_o is asserted, it and instr_addr_o stay stable until instr_gnt_i.
- On gnt: outstanding += 1; faddr += 4, wrapping modulo 2^32.
- On rvalid: outstanding -= 1. If discard > 0, discard -= 1 and drop the data. Otherwise push {addr of oldest outstanding, instr_rdata_i}. A 2-entry address queue tracks outstanding PCs.
- Pop on fetch_valid_o && fetch_ready_i. Push and pop in the same cycle are allowed at any occupancy, including full.
- The credit rule guarantees a push never occurs when full. Verification asserts this.
- Redirect (branch_i):
  - FIFO emptied.
  - faddr ← {branch_addr_i[31:2], 2'b00}.
  - discard ← outstanding after this cycle's gnt/rvalid updates.
  - A request pending without gnt is not retracted. When granted, it is counted as discard, and the new address is issued afterwards.
- rvalid in the same cycle as branch_i: data dropped.
- fetch_ready_i in the same cycle as branch_i: no pop, because fetch_valid_o is forced low.
- req_i low: no new requests are issued. FIFO contents and in-flight responses are retained.

## Timing
- Reset values:
  - instr_req_o = 0, instr_addr_o = BOOT_ADDR
  - fetch_valid_o = 0, fetch_rdata_o = 0, fetch_addr_o = BOOT_ADDR
  - busy_o = 0
  - faddr = BOOT_ADDR, counters 0, FIFO empty
- First instr_req_o: the cycle after rst_i deasserts, if req_i = 1.
- Redirect at cycle N with no pending ungranted request: instr_req_o with the new target at N+1.
- Grant at cycle G, rvalid at R ≥ G+1:
  - fetch_valid_o at R+1 (registered FIFO output), or at R with bypass (see Configuration).
- Sustained throughput: 1 instruction/cycle when gnt and rvalid are continuous and DEPTH ≥ 2.
- Reset asserted mid-transaction: all state cleared immediately. The bus owner must also be reset. No response is expected after reset.

## Configuration
- INSTR_PREFETCH_BYPASS_EN
  - Defined: when the FIFO is empty, rvalid arrives, no discard is pending and branch_i = 0, instr_rdata_i and its PC drive fetch_rdata_o/fetch_addr_o combinationally with fetch_valid_o = 1 in the same cycle. If fetch_ready_i = 1, the entry is not pushed; otherwise it is pushed.
  - Undefined: all data passes through the FIFO, adding one cycle of latency. Outputs are purely registered.

## Test plan
- Reset release, req_i = 1, gnt always 1, rvalid one cycle after gnt with rdata = addr ^ 32'hA5A5_A5A5 → instr_addr_o sequence 0, 4, 8…; fetch_addr_o/rdata pairs in order; 1 instr/cycle sustained.
- fetch_ready_i = 0 for 20 cycles → at most DEPTH entries buffered, instr_req_o drops, no push while full. Releasing ready drains entries 0x0..0xC in order.
- branch_i to 32'h0000_0102 with 2 outstanding → both responses dropped; next instr_addr_o = 0x100; first fetch_addr_o = 0x100.
- branch_i in the same cycle as rvalid and fetch_ready_i → no pop, data dropped, fetch_valid_o low next cycle.
- gnt held low 5 cycles after a request, branch mid-stall → instr_addr_o stable until gnt, that response discarded, then new target issued.
- faddr at 32'hFFFF_FFFC → next request wraps to 0x0. Run with and without INSTR_PREFETCH_BYPASS_EN, checking latency R vs R+1.

Source files
------------

// File: rtl/instr_prefetch_buf.sv
// instr_prefetch_buf: sequential instruction prefetcher between the instruction bus
// (req/gnt/rvalid) and the fetch stage (valid/ready). Returned words are queued with
// their PCs in a DEPTH-entry FIFO; a redirect flushes it and drops in-flight responses.
// Optional macro INSTR_PREFETCH_BYPASS_EN: when the FIFO is empty, a live response is
// forwarded combinationally to the fetch stage in the cycle it arrives.
module instr_prefetch_buf #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_rdata_o,
  output logic [31:0] fetch_addr_o,
  input  logic        fetch_ready_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        busy_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Fetch address and a redirect target parked behind an ungranted request
  logic [31:0]     faddr_q, faddr_d;
  logic [31:0]     btgt_q, btgt_d;
  logic            bpend_q, bpend_d;
  logic            hold_q, hold_d;
  logic [1:0]      outst_q, outst_d;
  logic [1:0]      disc_q, disc_d;
  // PCs of outstanding bus transactions, oldest at aq_rd_q
  logic [31:0]     aq_q [2];
  logic            aq_rd_q, aq_wr_q;
  logic [31:0]     fifo_addr_q [DEPTH];
  logic [31:0]     fifo_data_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            credit_ok, gnt, rvalid, drop, byp, byp_take, push, pop;
  logic [31:0]     aq_head, target;
  logic            unused_baddr;

  assign unused_baddr = ^branch_addr_i[1:0];
  assign target       = {branch_addr_i[31:2], 2'b00};
  assign aq_head      = aq_q[aq_rd_q];
  assign rvalid       = instr_rvalid_i;

  // Bus request: credit-limited, but held once raised until it is granted
  assign credit_ok    = (outst_q < 2'd2) && ((32'(cnt_q) + 32'(outst_q)) < DEPTH);
  assign instr_req_o  = ~rst_i & (hold_q | (req_i & credit_ok));
  assign instr_addr_o = faddr_q;
  assign gnt          = instr_req_o & instr_gnt_i;
  assign hold_d       = instr_req_o & ~instr_gnt_i;
  assign busy_o       = (outst_q != 2'd0);

  // Responses are dropped while stale ones drain or when a redirect arrives with them
  assign drop = (disc_q != 2'd0) | branch_i;
`ifdef INSTR_PREFETCH_BYPASS_EN
  assign byp  = (cnt_q == '0) & rvalid & (disc_q == 2'd0) & ~branch_i;
`else
  assign byp  = 1'b0;
`endif
  assign byp_take = byp & fetch_ready_i;
  assign push     = rvalid & ~drop & ~byp_take;
  assign pop      = (cnt_q != '0) & fetch_ready_i & ~branch_i;

  // Fetch-stage view: FIFO head, or the live response when bypassing
  always_comb begin
    fetch_valid_o = (cnt_q != '0) & ~branch_i;
    fetch_addr_o  = fifo_addr_q[rd_ptr_q];
    fetch_rdata_o = fifo_data_q[rd_ptr_q];
    if (byp) begin
      fetch_valid_o = 1'b1;
      fetch_addr_o  = aq_head;
      fetch_rdata_o = instr_rdata_i;
    end
  end

  // Outstanding and discard counters; a redirect marks everything in flight as stale
  always_comb begin
    outst_d = outst_q;
    if (gnt && !rvalid) begin
      outst_d = outst_q + 2'd1;
    end else if (!gnt && rvalid) begin
      outst_d = outst_q - 2'd1;
    end
    disc_d = disc_q;
    if (rvalid && (disc_q != 2'd0)) begin
      disc_d = disc_d - 2'd1;
    end
    // A request raised before a redirect returns stale data once granted
    if (gnt && bpend_q) begin
      disc_d = disc_d + 2'd1;
    end
    if (branch_i) begin
      disc_d = outst_d;
    end
  end

  // Fetch address: advance on grant, jump on redirect unless a request is still pending
  always_comb begin
    faddr_d = faddr_q;
    btgt_d  = btgt_q;
    bpend_d = bpend_q;
    if (gnt) begin
      if (bpend_q) begin
        faddr_d = btgt_q;
        bpend_d = 1'b0;
      end else begin
        faddr_d = faddr_q + 32'd4;
      end
    end
    if (branch_i) begin
      if (hold_d) begin
        bpend_d = 1'b1;
        btgt_d  = target;
      end else begin
        faddr_d = target;
        bpend_d = 1'b0;
      end
    end
  end

  // FIFO pointers and occupancy; a redirect empties the FIFO
  always_comb begin
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    cnt_d    = cnt_q + CntW'(push) - CntW'(pop);
    if (branch_i) begin
      wr_ptr_d = rd_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = '0;
    end
  end

  // Control state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      faddr_q  <= BOOT_ADDR;
      btgt_q   <= BOOT_ADDR;
      bpend_q  <= 1'b0;
      hold_q   <= 1'b0;
      outst_q  <= 2'd0;
      disc_q   <= 2'd0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      faddr_q  <= faddr_d;
      btgt_q   <= btgt_d;
      bpend_q  <= bpend_d;
      hold_q   <= hold_d;
      outst_q  <= outst_d;
      disc_q   <= disc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outstanding-PC queue: written on grant, retired on response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aq_q[0] <= BOOT_ADDR;
      aq_q[1] <= BOOT_ADDR;
      aq_rd_q <= 1'b0;
      aq_wr_q <= 1'b0;
    end else begin
      if (gnt) begin
        aq_q[aq_wr_q] <= faddr_q;
        aq_wr_q       <= ~aq_wr_q;
      end
      if (rvalid) begin
        aq_rd_q <= ~aq_rd_q;
      end
    end
  end

  // FIFO storage of {pc, instruction}
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_addr_q[i] <= BOOT_ADDR;
        fifo_data_q[i] <= 32'h0;
      end
    end else if (push) begin
      fifo_addr_q[wr_ptr_q] <= aq_head;
      fifo_data_q[wr_ptr_q] <= instr_rdata_i;
    end
  end

`ifndef SYNTHESIS
  // The credit rule keeps pushes away from a full FIFO
  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
                                   !(push && (cnt_q == CntW'(DEPTH))));
`endif

endmodule

// File: tb/tb_instr_prefetch_buf.sv
// Self-checking bench for instr_prefetch_buf: a directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_instr_prefetch_buf;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BOOT  = 32'h0000_0000;
  localparam logic [31:0] KEY   = 32'hA5A5_A5A5;
`ifdef INSTR_PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i, branch_i, fetch_ready_i, instr_gnt_i, instr_rvalid_i;
  logic [31:0] branch_addr_i, instr_rdata_i;
  logic        fetch_valid_o, instr_req_o, busy_o;
  logic [31:0] fetch_rdata_o, fetch_addr_o, instr_addr_o;

  always #5 clk_i = ~clk_i;

  instr_prefetch_buf #(.DEPTH(DEPTH), .BOOT_ADDR(BOOT)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_i         (req_i),
    .branch_i      (branch_i),
    .branch_addr_i (branch_addr_i),
    .fetch_valid_o (fetch_valid_o),
    .fetch_rdata_o (fetch_rdata_o),
    .fetch_addr_o  (fetch_addr_o),
    .fetch_ready_i (fetch_ready_i),
    .instr_req_o   (instr_req_o),
    .instr_addr_o  (instr_addr_o),
    .instr_gnt_i   (instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i (instr_rdata_i),
    .busy_o        (busy_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: buffered entries, PCs in flight, stale-response count
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;
  ent_t        m_fifo[$];
  logic [31:0] m_pcq[$];
  int          m_disc;
  logic [31:0] m_faddr, m_btgt;
  bit          m_hold, m_bpend;
  // Bus responder: granted addresses awaiting a response
  logic [31:0] bus_q[$];
  // Observed grants and consumed fetches
  logic [31:0] obs_g[$], obs_f[$], obs_d[$];
  // Model predictions for the current cycle
  bit          e_req, e_busy, e_valid;
  logic [31:0] e_addr, e_fa, e_fd;

  typedef struct {
    bit          req, gnt, rdy, rv;
    bit          e_req, e_busy, e_valid;
    logic [31:0] e_addr, e_faddr;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_missing(input string name);
    checks++;
    errors++;
    $display("FAIL %s: entry missing", name);
  endtask

  task automatic chk_fetch(input string name, input int idx, input logic [31:0] exp);
    if (idx < obs_f.size()) begin
      chk({name, "_addr"}, obs_f[idx], exp);
      chk({name, "_data"}, obs_d[idx], exp ^ KEY);
    end else begin
      fail_missing(name);
    end
  endtask

  task automatic chk_grant(input string name, input int idx, input logic [31:0] exp);
    if (idx < obs_g.size()) chk(name, obs_g[idx], exp);
    else fail_missing(name);
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_pcq.delete();
    m_disc  = 0;
    m_faddr = BOOT;
    m_btgt  = BOOT;
    m_hold  = 1'b0;
    m_bpend = 1'b0;
    bus_q.delete();
    obs_g.delete();
    obs_f.delete();
    obs_d.delete();
  endtask

  task automatic predict();
    e_req  = m_hold || (req_i && (m_pcq.size() < 2) &&
                        ((m_fifo.size() + m_pcq.size()) < int'(DEPTH)));
    e_addr = m_faddr;
    e_busy = (m_pcq.size() != 0);
    e_valid = 1'b0;
    e_fa    = '0;
    e_fd    = '0;
    if (!branch_i) begin
      if (m_fifo.size() != 0) begin
        e_valid = 1'b1;
        e_fa    = m_fifo[0].a;
        e_fd    = m_fifo[0].d;
      end else if (BYP && instr_rvalid_i && (m_disc == 0)) begin
        e_valid = 1'b1;
        e_fa    = m_pcq[0];
        e_fd    = instr_rdata_i;
      end
    end
  endtask

  // Called #1 after a rising edge: apply inputs, settle, compare against the model
  task automatic drive(input bit req, input bit br, input logic [31:0] ba,
                       input bit rdy, input bit gnt, input bit rven);
    req_i          = req;
    branch_i       = br;
    branch_addr_i  = ba;
    fetch_ready_i  = rdy;
    instr_gnt_i    = gnt;
    instr_rvalid_i = rven && (bus_q.size() != 0);
    instr_rdata_i  = instr_rvalid_i ? (bus_q[0] ^ KEY) : $urandom;
    #1;
    predict();
    chk("instr_req", 32'(instr_req_o), 32'(e_req));
    chk("instr_addr", instr_addr_o, e_addr);
    chk("busy", 32'(busy_o), 32'(e_busy));
    chk("fetch_valid", 32'(fetch_valid_o), 32'(e_valid));
    if (e_valid) begin
      chk("fetch_addr", fetch_addr_o, e_fa);
      chk("fetch_rdata", fetch_rdata_o, e_fd);
    end
    if (instr_req_o && instr_gnt_i) obs_g.push_back(instr_addr_o);
    if (fetch_valid_o && fetch_ready_i) begin
      obs_f.push_back(fetch_addr_o);
      obs_d.push_back(fetch_rdata_o);
    end
  endtask

  // Advance one clock; update the model from this cycle's inputs and predictions
  task automatic commit();
    bit          g, rv, br, bypc;
    logic [31:0] rdata, ba, pc, tgt;
    ent_t        e;
    g     = e_req && instr_gnt_i;
    rv    = instr_rvalid_i;
    br    = branch_i;
    rdata = instr_rdata_i;
    ba    = branch_addr_i;
    bypc  = 1'b0;
    if (e_valid && fetch_ready_i) begin
      if (m_fifo.size() != 0) void'(m_fifo.pop_front());
      else bypc = 1'b1;
    end
    @(posedge clk_i);
    if (rv) begin
      pc = m_pcq.pop_front();
      if (m_disc > 0) begin
        m_disc--;
      end else if (!br && !bypc) begin
        e.a = pc;
        e.d = rdata;
        m_fifo.push_back(e);
      end
      void'(bus_q.pop_front());
    end
    if (g) begin
      m_pcq.push_back(m_faddr);
      bus_q.push_back(m_faddr);
      if (m_bpend) begin
        m_faddr = m_btgt;
        m_bpend = 1'b0;
        m_disc++;
      end else begin
        m_faddr = m_faddr + 32'd4;
      end
    end
    m_hold = e_req && !g;
    if (br) begin
      m_fifo.delete();
      m_disc = m_pcq.size();
      tgt = {ba[31:2], 2'b00};
      if (e_req && !g) begin
        m_bpend = 1'b1;
        m_btgt  = tgt;
      end else begin
        m_faddr = tgt;
        m_bpend = 1'b0;
      end
    end
    #1;
  endtask

  task automatic step(input bit req, input bit br, input logic [31:0] ba,
                      input bit rdy, input bit gnt, input bit rven);
    drive(req, br, ba, rdy, gnt, rven);
    commit();
  endtask

  // Asynchronous reset with req_i high; outputs must clear immediately
  task automatic do_reset();
    rst_i          = 1'b1;
    req_i          = 1'b1;
    branch_i       = 1'b0;
    branch_addr_i  = '0;
    fetch_ready_i  = 1'b0;
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    #1;
    chk("rst_req", 32'(instr_req_o), 32'd0);
    chk("rst_iaddr", instr_addr_o, BOOT);
    chk("rst_valid", 32'(fetch_valid_o), 32'd0);
    chk("rst_rdata", fetch_rdata_o, 32'd0);
    chk("rst_faddr", fetch_addr_o, BOOT);
    chk("rst_busy", 32'(busy_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_reset();
  endtask

  initial begin
    int n0;
    for (int c = 0; c < 8; c++) begin
      vt[c].req     = 1'b1;
      vt[c].gnt     = 1'b1;
      vt[c].rdy     = 1'b1;
      vt[c].rv      = 1'b1;
      vt[c].e_req   = 1'b1;
      vt[c].e_addr  = 32'(4 * c);
      vt[c].e_busy  = (c >= 1);
      vt[c].e_valid = BYP ? (c >= 1) : (c >= 2);
      vt[c].e_faddr = BYP ? 32'(4 * (c - 1)) : 32'(4 * (c - 2));
    end

    // Streaming start-up: addresses 0,4,8..; first fetch at R (bypass) or R+1
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(vt[c].req, 1'b0, '0, vt[c].rdy, vt[c].gnt, vt[c].rv);
      chk("vec_req", 32'(instr_req_o), 32'(vt[c].e_req));
      chk("vec_iaddr", instr_addr_o, vt[c].e_addr);
      chk("vec_busy", 32'(busy_o), 32'(vt[c].e_busy));
      chk("vec_valid", 32'(fetch_valid_o), 32'(vt[c].e_valid));
      if (vt[c].e_valid) begin
        chk("vec_faddr", fetch_addr_o, vt[c].e_faddr);
        chk("vec_rdata", fetch_rdata_o, vt[c].e_faddr ^ KEY);
      end
      commit();
    end
    n0 = obs_f.size();
    for (int c = 0; c < 20; c++) step(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    chk("throughput", 32'(obs_f.size() - n0), 32'd20);
    for (int k = 0; k < obs_f.size(); k++) chk_fetch("stream", k, 32'(4 * k));

    // Backpressure: DEPTH entries buffered, requests stop, drain in order
    do_reset();
    for (int c = 0; c < 20; c++) step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk("full_req", 32'(instr_req_o), 32'd0);
    chk("full_valid", 32'(fetch_valid_o), 32'd1);
    chk("full_busy", 32'(busy_o), 32'd0);
    commit();
    for (int c = 0; c < 6; c++) step(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) chk_fetch("drain", k, 32'(4 * k));

    // Redirect with two responses in flight
    do_reset();
    step(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 32'h0000_0102, 1'b1, 1'b1, 1'b0);
    chk("br2_busy", 32'(busy_o), 32'd1);
    commit();
    obs_g.delete();
    obs_f.delete();
    obs_d.delete();
    for (int c = 0; c < 10; c++) step(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    chk_grant("br2_grant", 0, 32'h0000_0100);
    chk_fetch("br2_fetch", 0, 32'h0000_0100);

    // Redirect together with rvalid and fetch_ready: no pop, data dropped
    do_reset();
    for (int c = 0; c < 3; c++) step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 32'h0000_0400, 1'b1, 1'b0, 1'b1);
    chk("brrv_valid", 32'(fetch_valid_o), 32'd0);
    commit();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("brrv_valid_next", 32'(fetch_valid_o), 32'd0);
    commit();
    obs_f.delete();
    obs_d.delete();
    for (int c = 0; c < 8; c++) step(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    chk_fetch("brrv_fetch", 0, 32'h0000_0400);

    // Grant stall with a redirect mid-stall: address held, stale response dropped
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(c < 2, c == 2, 32'h0000_0200, 1'b1, c == 5, 1'b0);
      chk("stall_req", 32'(instr_req_o), 32'd1);
      chk("stall_addr", instr_addr_o, 32'h0000_0000);
      commit();
    end
    drive(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    chk("stall_new_req", 32'(instr_req_o), 32'd1);
    chk("stall_new_addr", instr_addr_o, 32'h0000_0200);
    commit();
    for (int c = 0; c < 8; c++) step(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    chk_fetch("stall_fetch", 0, 32'h0000_0200);

    // Address wrap at the top of the address space
    do_reset();
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 6; c++) step(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    chk_grant("wrap_g0", 0, 32'hFFFF_FFFC);
    chk_grant("wrap_g1", 1, 32'h0000_0000);
    chk_fetch("wrap_f0", 0, 32'hFFFF_FFFC);
    chk_fetch("wrap_f1", 1, 32'h0000_0000);

    // Randomized traffic against the model, with a reset in the middle
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      step($urandom_range(99) < 85, $urandom_range(99) < 4, $urandom,
           $urandom_range(99) < 70, $urandom_range(99) < 70, $urandom_range(99) < 60);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
